// File: rtl/queue_pkg.sv
// -----------------------------------------------------------------------------
// queue_pkg
// Shared definitions for the two-entry ready/valid queue controller:
//   QUEUE_WIDTH / QUEUE_DEPTH : default payload width and entry count
//   QUEUE_AW / QUEUE_CW       : pointer and occupancy-count widths
//   queue_ptr_t / queue_cnt_t : pointer and count types for the default build
//   ptr_inc()                 : wrapping pointer increment (DEPTH-1 -> 0)
// -----------------------------------------------------------------------------
package queue_pkg;

    localparam int QUEUE_WIDTH = 113;
    localparam int QUEUE_DEPTH = 2;
    localparam int QUEUE_AW    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int QUEUE_CW    = $clog2(QUEUE_DEPTH + 1);

    typedef logic [QUEUE_AW-1:0] queue_ptr_t;
    typedef logic [QUEUE_CW-1:0] queue_cnt_t;

    // Wrapping increment kept width-agnostic so any queue depth can share it;
    // callers cast the result back to their own pointer width.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/queue_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// queue_ptr_ctrl
// Occupancy tracker for the queue: enqueue/dequeue pointers plus maybe_full.
// Ports:
//   i_clock, i_reset     : clock, synchronous active-high reset
//   i_do_enq, i_do_deq   : completed enqueue / dequeue this cycle
//   o_enq_ptr, o_deq_ptr : current write / read slot
//   o_empty, o_full      : derived status
//   o_count              : current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module queue_ptr_ctrl
    import queue_pkg::*;
#(
    parameter  int DEPTH = QUEUE_DEPTH,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_do_enq,
    input  logic          i_do_deq,
    output logic [AW-1:0] o_enq_ptr,
    output logic [AW-1:0] o_deq_ptr,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);

    logic [AW-1:0] r_enq_ptr;
    logic [AW-1:0] r_deq_ptr;
    logic          r_maybe_full;

    logic [AW-1:0] w_enq_ptr_nxt;
    logic [AW-1:0] w_deq_ptr_nxt;
    logic [AW-1:0] w_ptr_diff;
    logic          w_ptr_match;
    logic [CW-1:0] w_count;

    assign w_enq_ptr_nxt = AW'(ptr_inc(32'(r_enq_ptr), 32'(DEPTH)));
    assign w_deq_ptr_nxt = AW'(ptr_inc(32'(r_deq_ptr), 32'(DEPTH)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_enq_ptr    <= '0;
            r_deq_ptr    <= '0;
            r_maybe_full <= 1'b0;
        end else begin
            if (i_do_enq) begin
                r_enq_ptr <= w_enq_ptr_nxt;
            end
            if (i_do_deq) begin
                r_deq_ptr <= w_deq_ptr_nxt;
            end
            // Equal pointers are ambiguous; the last unbalanced operation
            // tells whether they met by filling or by draining.
            if (i_do_enq != i_do_deq) begin
                r_maybe_full <= i_do_enq;
            end
        end
    end

    assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
    // Power-of-two depth: modular subtraction in AW bits gives the occupancy.
    assign w_ptr_diff  = r_enq_ptr - r_deq_ptr;

    // NOTE: default assignment first so no path through the block leaves
    // w_count unassigned, which would infer a latch.
    always_comb begin
        w_count = '0;
        if (w_ptr_match) begin
            w_count = r_maybe_full ? CW'(DEPTH) : '0;
        end else begin
            w_count = CW'(w_ptr_diff);
        end
    end

    assign o_enq_ptr = r_enq_ptr;
    assign o_deq_ptr = r_deq_ptr;
    assign o_empty   = w_ptr_match & ~r_maybe_full;
    assign o_full    = w_ptr_match & r_maybe_full;
    assign o_count   = w_count;

endmodule

// File: rtl/queue_2x113.sv
// -----------------------------------------------------------------------------
// queue_2x113
// Two-entry ready/valid FIFO controller driving both ports of an external
// ram_2x113-style array (write port on the enqueue side, combinational read
// port on the dequeue side).
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   io_enq_valid/ready/bits  : producer handshake and payload
//   io_deq_valid/ready/bits  : consumer handshake and oldest payload
//   io_count                 : current occupancy
//   ram_W0_addr/en/clk/data  : array write port
//   ram_R0_addr/en/clk/data  : array read port (ram_R0_data is combinational)
// Optional feature (macro QUEUE_FLOW_EN): when empty, an offered enqueue is
// presented on the dequeue side in the same cycle; if it is also accepted
// there, the array and pointers are left untouched.
// -----------------------------------------------------------------------------
module queue_2x113
    import queue_pkg::*;
#(
    parameter  int WIDTH = QUEUE_WIDTH,
    parameter  int DEPTH = QUEUE_DEPTH,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [WIDTH-1:0] io_enq_bits,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [WIDTH-1:0] io_deq_bits,
    output logic [CW-1:0]    io_count,
    output logic [AW-1:0]    ram_W0_addr,
    output logic             ram_W0_en,
    output logic             ram_W0_clk,
    output logic [WIDTH-1:0] ram_W0_data,
    output logic [AW-1:0]    ram_R0_addr,
    output logic             ram_R0_en,
    output logic             ram_R0_clk,
    input  logic [WIDTH-1:0] ram_R0_data
);

    logic [AW-1:0] w_enq_ptr;
    logic [AW-1:0] w_deq_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_do_enq;
    logic          w_do_deq;
    logic          w_bypass;
    logic          w_ctrl_enq;
    logic          w_ctrl_deq;

    // Full blocks enqueue even when a dequeue is happening: no pipe-through.
    assign io_enq_ready = ~w_full;

`ifdef QUEUE_FLOW_EN
    // Empty queue passes the producer's offer straight to the consumer.
    assign w_bypass     = w_empty & io_enq_valid & io_deq_ready;
    assign io_deq_valid = ~w_empty | io_enq_valid;
    assign io_deq_bits  = w_empty ? io_enq_bits : ram_R0_data;
`else
    assign w_bypass     = 1'b0;
    assign io_deq_valid = ~w_empty;
    assign io_deq_bits  = ram_R0_data;
`endif

    assign w_do_enq = io_enq_valid & io_enq_ready;
    assign w_do_deq = io_deq_valid & io_deq_ready;

    // A bypassed transfer never touches storage, so it is hidden from the
    // pointer logic on both sides.
    assign w_ctrl_enq = w_do_enq & ~w_bypass;
    assign w_ctrl_deq = w_do_deq & ~w_bypass;

    queue_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_do_enq  (w_ctrl_enq),
        .i_do_deq  (w_ctrl_deq),
        .o_enq_ptr (w_enq_ptr),
        .o_deq_ptr (w_deq_ptr),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_count   (io_count)
    );

    // NOTE: the array itself is never cleared; reset only empties the
    // pointers, which makes stale entries unreachable.
    assign ram_W0_addr = w_enq_ptr;
    assign ram_W0_en   = w_ctrl_enq & ~reset;
    assign ram_W0_clk  = clock;
    assign ram_W0_data = io_enq_bits;

    assign ram_R0_addr = w_deq_ptr;
    assign ram_R0_en   = 1'b1;
    assign ram_R0_clk  = clock;

endmodule

// File: tb/tb_queue_2x113.sv
// -----------------------------------------------------------------------------
// tb_queue_2x113
// Self-checking bench for queue_2x113. Holds a behavioural array model on the
// RAM ports and a reference FIFO (SV queue) for expected values.
// Honours QUEUE_FLOW_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_queue_2x113;
    import queue_pkg::*;

    localparam int WIDTH = QUEUE_WIDTH;
    localparam int DEPTH = QUEUE_DEPTH;
    localparam int AW    = QUEUE_AW;
    localparam int CW    = QUEUE_CW;
`ifdef QUEUE_FLOW_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    typedef logic [WIDTH-1:0] data_t;

    logic          clock;
    logic          reset;
    logic          io_enq_valid;
    logic          io_enq_ready;
    data_t         io_enq_bits;
    logic          io_deq_valid;
    logic          io_deq_ready;
    data_t         io_deq_bits;
    logic [CW-1:0] io_count;
    logic [AW-1:0] ram_W0_addr;
    logic          ram_W0_en;
    logic          ram_W0_clk;
    data_t         ram_W0_data;
    logic [AW-1:0] ram_R0_addr;
    logic          ram_R0_en;
    logic          ram_R0_clk;
    data_t         ram_R0_data;

    int checks;
    int errors;

    // Reference model: FIFO contents and writes since the last reset.
    data_t       mq[$];
    int unsigned wr_cnt;

    // Behavioural array: synchronous write, combinational read.
    data_t mem [DEPTH];

    queue_2x113 dut (
        .clock        (clock),
        .reset        (reset),
        .io_enq_valid (io_enq_valid),
        .io_enq_ready (io_enq_ready),
        .io_enq_bits  (io_enq_bits),
        .io_deq_valid (io_deq_valid),
        .io_deq_ready (io_deq_ready),
        .io_deq_bits  (io_deq_bits),
        .io_count     (io_count),
        .ram_W0_addr  (ram_W0_addr),
        .ram_W0_en    (ram_W0_en),
        .ram_W0_clk   (ram_W0_clk),
        .ram_W0_data  (ram_W0_data),
        .ram_R0_addr  (ram_R0_addr),
        .ram_R0_en    (ram_R0_en),
        .ram_R0_clk   (ram_R0_clk),
        .ram_R0_data  (ram_R0_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge ram_W0_clk) begin
        if (ram_W0_en) begin
            mem[ram_W0_addr] <= ram_W0_data;
        end
    end
    assign ram_R0_data = ram_R0_en ? mem[ram_R0_addr] : 'x;

    function automatic data_t rand_bits();
        data_t v;
        v[31:0]   = $urandom();
        v[63:32]  = $urandom();
        v[95:64]  = $urandom();
        v[112:96] = 17'($urandom());
        return v;
    endfunction

    // Expected values derived from the FIFO contents and the current inputs.
    function automatic bit exp_deq_valid();
        return (mq.size() > 0) || (FLOW && io_enq_valid);
    endfunction

    function automatic data_t exp_deq_bits();
        return (mq.size() > 0) ? mq[0] : io_enq_bits;
    endfunction

    function automatic bit exp_wen();
        return !reset && io_enq_valid && (mq.size() < DEPTH)
               && !(FLOW && (mq.size() == 0) && io_deq_ready);
    endfunction

    function automatic logic [AW-1:0] exp_waddr();
        return AW'(wr_cnt % DEPTH);
    endfunction

    task automatic drive(input bit ev, input data_t eb, input bit dr, input bit rs);
        io_enq_valid = ev;
        io_enq_bits  = eb;
        io_deq_ready = dr;
        reset        = rs;
        #1;
    endtask

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic step();
        bit empty;
        bit full;
        bit bypass;
        bit de;
        bit en;
        data_t eb;
        bit rs;
        empty  = (mq.size() == 0);
        full   = (mq.size() == DEPTH);
        bypass = FLOW && empty && io_enq_valid && io_deq_ready;
        de     = !empty && io_deq_ready;
        en     = io_enq_valid && !full && !bypass;
        eb     = io_enq_bits;
        rs     = reset;
        @(posedge clock);
        if (rs) begin
            mq.delete();
            wr_cnt = 0;
        end else begin
            if (de) void'(mq.pop_front());
            if (en) begin
                mq.push_back(eb);
                wr_cnt++;
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        drive(1'b1, 113'h1DEAD, 1'b0, 1'b1);
        step();
        step();
        checks++;
        if (ram_W0_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_wen_in_reset: got %b expected 0", ram_W0_en);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (io_enq_ready !== 1'b1 || io_deq_valid !== 1'b0 || io_count !== '0) begin
                errors++;
                $display("FAIL reset_idle: got ready=%b valid=%b count=%0d expected 1 0 0",
                         io_enq_ready, io_deq_valid, io_count);
            end
            checks++;
            if (ram_W0_en !== 1'b0 || ram_R0_en !== 1'b1 || ram_R0_clk !== clock) begin
                errors++;
                $display("FAIL reset_ram_ports: got w_en=%b r_en=%b r_clk=%b expected 0 1 %b",
                         ram_W0_en, ram_R0_en, ram_R0_clk, clock);
            end
            step();
        end
    endtask

    task automatic test_fill();
        data_t vals [3];
        vals[0] = 113'h1AAAA;
        vals[1] = 113'h1BBBB;
        vals[2] = 113'h1CCCC;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 1'b0, 1'b0);
            checks++;
            if (ram_W0_en !== (i < 2) || (i < 2 && ram_W0_addr !== AW'(i))
                || (i < 2 && ram_W0_data !== vals[i])) begin
                errors++;
                $display("FAIL fill_write%0d: got en=%b addr=%0d data=%h expected en=%b addr=%0d data=%h",
                         i, ram_W0_en, ram_W0_addr, ram_W0_data, (i < 2), i, vals[i]);
            end
            step();
            checks++;
            if (io_count !== CW'((i < 2) ? i + 1 : 2)) begin
                errors++;
                $display("FAIL fill_count%0d: got %0d expected %0d", i, io_count, (i < 2) ? i + 1 : 2);
            end
        end
        checks++;
        if (io_enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full_ready: got %b expected 0", io_enq_ready);
        end
    endtask

    task automatic test_drain();
        data_t exp [2];
        exp[0] = 113'h1AAAA;
        exp[1] = 113'h1BBBB;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (io_deq_valid !== 1'b1 || io_deq_bits !== exp[i] || io_count !== CW'(2 - i)) begin
                errors++;
                $display("FAIL drain%0d: got valid=%b bits=%h count=%0d expected 1 %h %0d",
                         i, io_deq_valid, io_deq_bits, io_count, exp[i], 2 - i);
            end
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (io_deq_valid !== 1'b0 || io_count !== '0) begin
            errors++;
            $display("FAIL drain_empty: got valid=%b count=%0d expected 0 0", io_deq_valid, io_count);
        end
    endtask

    task automatic test_stream_wrap();
        data_t exp;
        drive(1'b1, 113'h77, 1'b0, 1'b0);
        step();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, data_t'(i), 1'b1, 1'b0);
            exp = (i == 1) ? 113'h77 : data_t'(i - 1);
            checks++;
            if (io_count !== CW'(1) || io_deq_valid !== 1'b1 || io_deq_bits !== exp
                || io_enq_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream%0d: got count=%0d valid=%b bits=%h ready=%b expected 1 1 %h 1",
                         i, io_count, io_deq_valid, io_deq_bits, io_enq_ready, exp);
            end
            checks++;
            if (ram_W0_en !== 1'b1 || ram_W0_addr !== exp_waddr()) begin
                errors++;
                $display("FAIL stream_waddr%0d: got en=%b addr=%0d expected 1 %0d",
                         i, ram_W0_en, ram_W0_addr, exp_waddr());
            end
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (io_deq_bits !== data_t'(6) || io_count !== CW'(1)) begin
            errors++;
            $display("FAIL stream_tail: got bits=%h count=%0d expected 6 1", io_deq_bits, io_count);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 113'hA1, 1'b0, 1'b0);
        step();
        drive(1'b1, 113'hA2, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (io_count !== CW'(2)) begin
            errors++;
            $display("FAIL resetmid_pre: got count=%0d expected 2", io_count);
        end
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (io_count !== '0 || io_deq_valid !== 1'b0 || io_enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_post: got count=%0d valid=%b ready=%b expected 0 0 1",
                     io_count, io_deq_valid, io_enq_ready);
        end
        drive(1'b1, 113'h0F00D, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (io_deq_valid !== 1'b1 || io_deq_bits !== 113'h0F00D) begin
            errors++;
            $display("FAIL resetmid_first: got valid=%b bits=%h expected 1 0f00d", io_deq_valid, io_deq_bits);
        end
        step();
    endtask

    task automatic test_flow();
        drive(1'b1, 113'h12345, 1'b1, 1'b0);
        checks++;
        if (io_deq_valid !== FLOW || ram_W0_en !== !FLOW
            || (FLOW && io_deq_bits !== 113'h12345)) begin
            errors++;
            $display("FAIL flow_same_cycle: got valid=%b bits=%h w_en=%b expected valid=%b w_en=%b",
                     io_deq_valid, io_deq_bits, ram_W0_en, FLOW, !FLOW);
        end
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (io_count !== CW'(FLOW ? 0 : 1) || io_deq_valid !== !FLOW
            || (!FLOW && io_deq_bits !== 113'h12345)) begin
            errors++;
            $display("FAIL flow_next_cycle: got count=%0d valid=%b bits=%h expected count=%0d valid=%b",
                     io_count, io_deq_valid, io_deq_bits, FLOW ? 0 : 1, !FLOW);
        end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, rand_bits(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0);
            checks++;
            if (io_enq_ready !== (mq.size() < DEPTH) || io_count !== CW'(mq.size())) begin
                errors++;
                $display("FAIL rand_status@%0d: got ready=%b count=%0d expected %b %0d",
                         n, io_enq_ready, io_count, (mq.size() < DEPTH), mq.size());
            end
            checks++;
            if (io_deq_valid !== exp_deq_valid()
                || (exp_deq_valid() && io_deq_bits !== exp_deq_bits())) begin
                errors++;
                $display("FAIL rand_deq@%0d: got valid=%b bits=%h expected %b %h",
                         n, io_deq_valid, io_deq_bits, exp_deq_valid(), exp_deq_bits());
            end
            checks++;
            if (ram_W0_en !== exp_wen()
                || (exp_wen() && (ram_W0_addr !== exp_waddr() || ram_W0_data !== io_enq_bits))) begin
                errors++;
                $display("FAIL rand_write@%0d: got en=%b addr=%0d expected en=%b addr=%0d",
                         n, ram_W0_en, ram_W0_addr, exp_wen(), exp_waddr());
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr_cnt = 0;
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clock);
        test_reset();
        test_fill();
        test_drain();
        test_stream_wrap();
        test_reset_mid();
        test_flow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
